dsp_op_sequencer: RTL and testbench
===================================

DSP_OP_SEQUENCER -- requirements
Module: dsp_op_sequencer

Interface
REQ-001 Parameter LATENCY, default 3, DSP slice clock edges from operand drive to P-register update; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer accepts command this cycle.
REQ-007 cmd_a, cmd_b, cmd_d  in  18 each  DSP A/B/D operands.
REQ-008 cmd_c  in  48  DSP C operand.
REQ-009 cmd_opmode  in  8  DSP OPMODE for this operation.
REQ-010 cmd_carryin  in  1  DSP CARRYIN for this operation.
REQ-011 dsp_a, dsp_b, dsp_d  out  18 each; dsp_c  out  48; dsp_opmode  out  8; dsp_carryin  out  1: registered drives to the DSP slice.
REQ-012 dsp_ce  out  1  common clock enable for all DSP slice register stages.
REQ-013 dsp_rst  out  1  common reset for all DSP slice register stages.
REQ-014 dsp_p  in  48; dsp_carryout  in  1: DSP slice results.
REQ-015 rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-016 rsp_p  out  48; rsp_carryout  out  1: captured result.
REQ-017 op_count  out  CNT_W  number of completed responses.

Function
REQ-018 States: IDLE, WAIT, RESP; exactly one operation in flight.
REQ-019 IDLE: cmd_ready=1, dsp_ce=0, rsp_valid=0.
REQ-020 Accept on edge k when cmd_valid&&cmd_ready: all cmd_* fields registered onto dsp_* outputs, wait counter loaded with LATENCY, state -> WAIT.
REQ-021 dsp_* drive outputs hold their value from acceptance until the next acceptance; they never change in WAIT or RESP.
REQ-022 WAIT: cmd_ready=0, dsp_ce=1, counter decrements each edge; on the edge where the counter is 0, dsp_p/dsp_carryout are captured into rsp_p/rsp_carryout and state -> RESP.
REQ-023 Capture edge is k+LATENCY+1; rsp_valid first high in the cycle after that edge, i.e. LATENCY+1 cycles after acceptance.
REQ-024 RESP: cmd_ready=0, dsp_ce=0, rsp_valid=1; rsp_p/rsp_carryout stable while rsp_valid && !rsp_ready.
REQ-025 rsp_valid&&rsp_ready: state -> IDLE, op_count increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-026 cmd_valid is ignored outside IDLE; no command is accepted in the cycle a response completes.
REQ-027 rsp_ready outside RESP has no effect.
REQ-028 dsp_rst is a register: 1 on every edge with RST=1, 0 on the first edge with RST=0.
REQ-029 No combinational path from any input to any output except none; all outputs come from registers or state decode.

Reset
REQ-030 RST=1 on any edge, in any state (including mid-WAIT or RESP): state -> IDLE, in-flight operation discarded, rsp_valid=0, op_count=0.
REQ-031 Reset values: dsp_a/b/c/d=0, dsp_opmode=0, dsp_carryin=0, dsp_ce=0, dsp_rst=1, rsp_p=0, rsp_carryout=0, wait counter=0, cmd_ready=0 while RST=1, 1 in the first cycle after RST deasserts.

Verification
REQ-032 Reset then A=2,B=2,D=5,C=20,OPMODE=0x1D,CARRYIN=0 with DSP slice at A1REG/MREG/PREG=1 -> rsp_valid 4 cycles after accept, rsp_p=34, op_count=1.
REQ-033 D=11,B=5,A=2,OPMODE=0x13 (pre-add, Z=0, X=D:A:B) -> rsp_p equals {D[11:0],A,B} concatenation value from slice; dsp_* stable during WAIT.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP with cmd_valid=1 -> rsp_p unchanged, cmd_ready=0, no second accept, op_count unchanged until handshake.
REQ-035 Assert RST for 1 cycle two cycles after accept -> rsp_valid never asserts for that op, dsp_rst=1 one cycle, op_count=0, cmd_ready=1 next cycle.
REQ-036 CNT_W=2, four back-to-back operations with rsp_ready=1 -> op_count sequence 1,2,3,0.
REQ-037 LATENCY=1 with stub returning dsp_p=dsp_c delayed 1 edge, C=0xABCD -> rsp_valid 2 cycles after accept, rsp_p=0xABCD.

Source files
------------

// File: rtl/dsp_op_sequencer.sv
// Sequences one DSP-slice operation at a time: registers operands, waits out the slice pipeline, holds the result.
// Latency: response valid LATENCY+1 cycles after command acceptance.
// Backpressure: cmd_ready low from accept until the response handshake; result held while rsp_ready is low.
module dsp_op_sequencer #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [17:0]      cmd_a,
    input  logic [17:0]      cmd_b,
    input  logic [17:0]      cmd_d,
    input  logic [47:0]      cmd_c,
    input  logic [7:0]       cmd_opmode,
    input  logic             cmd_carryin,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_carryin,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [47:0]      rsp_p,
    output logic             rsp_carryout,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       capture;
    logic       complete;

    // cmd_ready is gated by the registered slice reset so it stays low through reset without a comb path from rst
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        dsp_ce    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !dsp_rst;
                if (cmd_valid && !dsp_rst) state_nxt = WAIT;
            end
            WAIT: begin
                dsp_ce = 1'b1;
                if (wait_cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign capture  = (state == WAIT) && (wait_cnt == 4'd0);
    assign complete = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            dsp_a        <= '0;
            dsp_b        <= '0;
            dsp_d        <= '0;
            dsp_c        <= '0;
            dsp_opmode   <= '0;
            dsp_carryin  <= 1'b0;
            dsp_rst      <= 1'b1;
            rsp_p        <= '0;
            rsp_carryout <= 1'b0;
            op_count     <= '0;
        end else begin
            state   <= state_nxt;
            dsp_rst <= 1'b0;
            if (accept) begin
                dsp_a       <= cmd_a;
                dsp_b       <= cmd_b;
                dsp_d       <= cmd_d;
                dsp_c       <= cmd_c;
                dsp_opmode  <= cmd_opmode;
                dsp_carryin <= cmd_carryin;
                wait_cnt    <= 4'(LATENCY);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (capture) begin
                rsp_p        <= dsp_p;
                rsp_carryout <= dsp_carryout;
            end
            if (complete) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Bench for dsp_op_sequencer: two instances (LATENCY=3/CNT_W=16 and LATENCY=1/CNT_W=2) each driving a pipelined slice stub.
module tb_dsp_op_sequencer;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        cmd_valid, cmd_ready, cmd_carryin;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic [7:0]  cmd_opmode;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c, dsp_p, rsp_p;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce, dsp_rst, dsp_carryout;
    logic        rsp_valid, rsp_ready, rsp_carryout;
    logic [15:0] op_count;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_carryin;
    logic [17:0] b_cmd_a, b_cmd_b, b_cmd_d;
    logic [47:0] b_cmd_c;
    logic [7:0]  b_cmd_opmode;
    logic [17:0] b_dsp_a, b_dsp_b, b_dsp_d;
    logic [47:0] b_dsp_c, b_dsp_p, b_rsp_p;
    logic [7:0]  b_dsp_opmode;
    logic        b_dsp_carryin, b_dsp_ce, b_dsp_rst, b_dsp_carryout;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_carryout;
    logic [1:0]  b_op_count;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] a_cnt_exp;
    logic [48:0] sb_q[$];
    logic [48:0] b_q[$];

    dsp_op_sequencer #(.LATENCY(LAT_A), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c),
        .cmd_opmode(cmd_opmode), .cmd_carryin(cmd_carryin),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_carryout(rsp_carryout), .op_count(op_count)
    );

    dsp_op_sequencer #(.LATENCY(LAT_B), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_a(b_cmd_a), .cmd_b(b_cmd_b), .cmd_d(b_cmd_d), .cmd_c(b_cmd_c),
        .cmd_opmode(b_cmd_opmode), .cmd_carryin(b_cmd_carryin),
        .dsp_a(b_dsp_a), .dsp_b(b_dsp_b), .dsp_d(b_dsp_d), .dsp_c(b_dsp_c),
        .dsp_opmode(b_dsp_opmode), .dsp_carryin(b_dsp_carryin), .dsp_ce(b_dsp_ce), .dsp_rst(b_dsp_rst),
        .dsp_p(b_dsp_p), .dsp_carryout(b_dsp_carryout), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_p(b_rsp_p), .rsp_carryout(b_rsp_carryout), .op_count(b_op_count)
    );

    // Slice stub: first stage computes, remaining stages delay; P valid LAT edges after operands are driven.
    function automatic logic [47:0] dsp_model(input logic [17:0] a, input logic [17:0] b,
                                              input logic [17:0] d, input logic [47:0] c,
                                              input logic [7:0] opm, input logic cin);
        logic [47:0] pre;
        pre = 48'(d) + 48'(a);
        case (opm)
            8'h1D:   return pre * 48'(b) + c + 48'(cin);
            8'h13:   return {d[11:0], a, b};
            default: return c + 48'(cin);
        endcase
    endfunction

    logic [48:0] a_pipe [LAT_A];
    logic [48:0] b_pipe [LAT_B];

    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int i = 0; i < LAT_A; i++) a_pipe[i] <= '0;
        end else if (dsp_ce) begin
            a_pipe[0] <= {dsp_carryin, dsp_model(dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin)};
            for (int i = 1; i < LAT_A; i++) a_pipe[i] <= a_pipe[i-1];
        end
    end
    assign {dsp_carryout, dsp_p} = a_pipe[LAT_A-1];

    always @(posedge clk) begin
        if (b_dsp_rst) begin
            for (int j = 0; j < LAT_B; j++) b_pipe[j] <= '0;
        end else if (b_dsp_ce) begin
            b_pipe[0] <= {b_dsp_carryin, dsp_model(b_dsp_a, b_dsp_b, b_dsp_d, b_dsp_c, b_dsp_opmode, b_dsp_carryin)};
            for (int j = 1; j < LAT_B; j++) b_pipe[j] <= b_pipe[j-1];
        end
    end
    assign {b_dsp_carryout, b_dsp_p} = b_pipe[LAT_B-1];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (cmd_ready !== 1'b0 || dsp_rst !== 1'b1 || dsp_ce !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL reset_ctrl: ready=%b dsp_rst=%b ce=%b rsp_valid=%b want 0 1 0 0", cmd_ready, dsp_rst, dsp_ce, rsp_valid);
        else n_pass++;
        n_chk++;
        if ({dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin} !== '0)
            $display("FAIL reset_drives: dsp_a=%h dsp_c=%h opmode=%h want 0", dsp_a, dsp_c, dsp_opmode);
        else n_pass++;
        n_chk++;
        if ({rsp_p, rsp_carryout} !== 49'd0 || op_count !== 16'd0 || b_op_count !== 2'd0)
            $display("FAIL reset_rsp: rsp_p=%h op_count=%0d b_op_count=%0d want 0", rsp_p, op_count, b_op_count);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (cmd_ready !== 1'b1 || dsp_rst !== 1'b0 || b_cmd_ready !== 1'b1 || b_dsp_rst !== 1'b0)
            $display("FAIL reset_release: ready=%b dsp_rst=%b b_ready=%b b_dsp_rst=%b want 1 0 1 0", cmd_ready, dsp_rst, b_cmd_ready, b_dsp_rst);
        else n_pass++;
        a_cnt_exp = 16'd0;
    endtask

    // One op on instance A: checks latency, operand hold during WAIT, result hold under backpressure, completion.
    task automatic run_op(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                          input logic [47:0] c, input logic [7:0] opm, input logic cin,
                          input logic [47:0] exp_p, input int hold);
        int n;
        logic [48:0] exp_r;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_ready: cmd_ready=%b want 1", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_d = d; cmd_c = c; cmd_opmode = opm; cmd_carryin = cin;
        sb_q.push_back({cin, exp_p});
        tick();
        cmd_a = ~a; cmd_b = ~b; cmd_d = ~d; cmd_c = ~c; cmd_opmode = ~opm; cmd_carryin = ~cin;
        n = 0;
        while (rsp_valid !== 1'b1 && n <= 20) begin
            n_chk++;
            if ({dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin} !== {a, b, d, c, opm, cin} ||
                cmd_ready !== 1'b0 || dsp_ce !== 1'b1)
                $display("FAIL wait_hold: cycle %0d dsp_a=%h dsp_c=%h ready=%b ce=%b want a=%h c=%h ready=0 ce=1",
                         n, dsp_a, dsp_c, cmd_ready, dsp_ce, a, c);
            else n_pass++;
            tick();
            n++;
        end
        n_chk++;
        if (n !== LAT_A + 1) $display("FAIL latency: rsp_valid after %0d cycles want %0d", n, LAT_A + 1);
        else n_pass++;
        rsp_ready = 1'b0;
        repeat (hold) begin
            tick();
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_p !== exp_p || cmd_ready !== 1'b0 || dsp_ce !== 1'b0 ||
                op_count !== a_cnt_exp || dsp_a !== a)
                $display("FAIL resp_hold: valid=%b rsp_p=%h ready=%b ce=%b count=%0d dsp_a=%h want 1 %h 0 0 %0d %h",
                         rsp_valid, rsp_p, cmd_ready, dsp_ce, op_count, dsp_a, exp_p, a_cnt_exp, a);
            else n_pass++;
        end
        n_chk++;
        if (sb_q.size() == 0) $display("FAIL scoreboard: response with empty queue");
        else begin
            exp_r = sb_q.pop_front();
            if ({rsp_carryout, rsp_p} !== exp_r)
                $display("FAIL rsp_p: got co=%b p=%h want co=%b p=%h", rsp_carryout, rsp_p, exp_r[48], exp_r[47:0]);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        a_cnt_exp = a_cnt_exp + 16'd1;
        n_chk++;
        if (op_count !== a_cnt_exp || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || dsp_a !== a)
            $display("FAIL complete: count=%0d valid=%b ready=%b dsp_a=%h want %0d 0 1 %h",
                     op_count, rsp_valid, cmd_ready, dsp_a, a_cnt_exp, a);
        else n_pass++;
        cmd_valid = 1'b0;
    endtask

    task automatic test_accept_latency();
        run_op(18'd2, 18'd2, 18'd5, 48'd20, 8'h1D, 1'b0, 48'd34, 0);
    endtask

    task automatic test_preadd_concat_hold();
        run_op(18'd2, 18'd5, 18'd11, 48'h1234, 8'h13, 1'b0, {12'd11, 18'd2, 18'd5}, 5);
    endtask

    // Instance B (LATENCY=1): runs an op and checks 2-cycle latency plus scoreboard result.
    task automatic b_op(input logic [47:0] c, input logic cin, input logic [47:0] exp_p);
        int n;
        logic [48:0] exp_r;
        n_chk++;
        if (b_cmd_ready !== 1'b1) $display("FAIL b_idle_ready: cmd_ready=%b want 1", b_cmd_ready);
        else n_pass++;
        b_cmd_valid = 1'b1; b_cmd_c = c; b_cmd_carryin = cin; b_cmd_opmode = 8'h00;
        b_q.push_back({cin, exp_p});
        tick();
        b_cmd_valid = 1'b0;
        n = 0;
        while (b_rsp_valid !== 1'b1 && n <= 20) begin
            tick();
            n++;
        end
        n_chk++;
        if (n !== LAT_B + 1) $display("FAIL b_latency: rsp_valid after %0d cycles want %0d", n, LAT_B + 1);
        else n_pass++;
        n_chk++;
        if (b_q.size() == 0) $display("FAIL b_scoreboard: response with empty queue");
        else begin
            exp_r = b_q.pop_front();
            if ({b_rsp_carryout, b_rsp_p} !== exp_r)
                $display("FAIL b_rsp_p: got co=%b p=%h want co=%b p=%h", b_rsp_carryout, b_rsp_p, exp_r[48], exp_r[47:0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int seq [4];
        seq = '{1, 2, 3, 0};
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_op(48'(i * 16 + 3), 1'(i & 1), 48'(i * 16 + 3 + (i & 1)));
            tick();
            n_chk++;
            if (b_op_count !== 2'(seq[i])) $display("FAIL b_count: op %0d count=%0d want %0d", i, b_op_count, seq[i]);
            else n_pass++;
        end
        b_rsp_ready = 1'b0;
    endtask

    task automatic test_lat1();
        b_op(48'hABCD, 1'b0, 48'hABCD);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;
        n_chk++;
        if (b_op_count !== 2'd1 || b_rsp_valid !== 1'b0) $display("FAIL b_lat1_done: count=%0d valid=%b want 1 0", b_op_count, b_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        cmd_valid = 1'b1; cmd_c = 48'd777; cmd_opmode = 8'h00; cmd_carryin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_chk++;
        if (dsp_rst !== 1'b1 || rsp_valid !== 1'b0 || op_count !== 16'd0 || cmd_ready !== 1'b0 || dsp_c !== 48'd0 || dsp_ce !== 1'b0)
            $display("FAIL mid_reset: dsp_rst=%b valid=%b count=%0d ready=%b dsp_c=%h ce=%b want 1 0 0 0 0 0",
                     dsp_rst, rsp_valid, op_count, cmd_ready, dsp_c, dsp_ce);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (dsp_rst !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL mid_release: dsp_rst=%b ready=%b want 0 1", dsp_rst, cmd_ready);
        else n_pass++;
        seen = 1'b0;
        repeat (8) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_chk++;
        if (seen !== 1'b0 || op_count !== 16'd0) $display("FAIL mid_discard: rsp_valid seen=%b count=%0d want 0 0", seen, op_count);
        else n_pass++;
        a_cnt_exp = 16'd0;
    endtask

    task automatic test_recover();
        run_op(18'd3, 18'd4, 18'd0, 48'd100, 8'h1D, 1'b1, 48'd113, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_d = '0; cmd_c = '0; cmd_opmode = '0; cmd_carryin = 1'b0;
        rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_a = '0; b_cmd_b = '0; b_cmd_d = '0; b_cmd_c = '0; b_cmd_opmode = '0; b_cmd_carryin = 1'b0;
        b_rsp_ready = 1'b0;
        a_cnt_exp = 16'd0;
        @(negedge clk);
        test_reset();
        test_accept_latency();
        test_preadd_concat_hold();
        test_back_to_back();
        test_lat1();
        test_reset_mid_wait();
        test_recover();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
